// File: rtl/ofifo_multi_mode.sv
// Multi-column output FIFO with row-parallel and column-serial read modes.
// Each column is an independent circular buffer with its own write strobe.
// Mode 0 pops one entry from every column at once. Mode 1 pops one column at a
// time, rotating through the columns with an internal selector.
// Optional feature: define OFIFO_ERR_FLAGS_EN to build the sticky overflow and
// underflow flags. Without it, o_ovf and o_unf are tied low.
module ofifo_multi_mode #(
    parameter int unsigned COL    = 8,
    parameter int unsigned BW     = 4,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AF_LVL = DEPTH - 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned IW    = (COL > 1) ? $clog2(COL) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COL*BW-1:0] in,
    input  logic [COL-1:0]    wr,
    input  logic              rd,
    input  logic              mode,
    output logic [COL*BW-1:0] out,
    output logic [BW-1:0]     out_col,
    output logic [IW-1:0]     out_idx,
    output logic              out_vld,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_valid,
    output logic              o_afull,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT   = AF_LVL[AW:0];
    localparam logic [IW-1:0] LAST_SEL = IW'(COL - 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     r_wptr [COL];
    logic [AW:0]     r_rptr [COL];
    logic [BW-1:0]   r_mem  [COL][DEPTH];

    logic [COL*BW-1:0] r_out;
    logic [BW-1:0]     r_out_col;
    logic [IW-1:0]     r_out_idx;
    logic              r_out_vld;
    logic              r_mode;
    logic [IW-1:0]     r_sel;

    logic [AW:0]     w_cnt  [COL];
    logic [BW-1:0]   w_head [COL];
    logic [COL-1:0]  w_full;
    logic [COL-1:0]  w_empty;
    logic [COL-1:0]  w_afull;
    logic [COL-1:0]  w_pop;
    logic [COL-1:0]  w_push;
    logic            w_valid;
    logic            w_rd_ok;
    logic            w_pop_row;
    logic            w_pop_ser;

    // Per-column occupancy, flags and head-of-queue data.
    always_comb begin
        for (int i = 0; i < COL; i++) begin
            w_cnt[i]   = r_wptr[i] - r_rptr[i];
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = (w_cnt[i] == FULL_CNT);
            w_afull[i] = (w_cnt[i] >= AF_CNT);
            w_head[i]  = r_mem[i][r_rptr[i][AW-1:0]];
        end
    end

    // Read qualification and per-column pop/push decisions.
    always_comb begin
        w_valid   = r_mode ? ~w_empty[r_sel] : ~(|w_empty);
        w_rd_ok   = rd & w_valid;
        w_pop_row = w_rd_ok & ~r_mode;
        w_pop_ser = w_rd_ok & r_mode;
        for (int i = 0; i < COL; i++) begin
            w_pop[i]  = w_pop_row | (w_pop_ser & (r_sel == IW'(i)));
            // A full column accepts a write only when it is popped in the same cycle.
            w_push[i] = wr[i] & (~w_full[i] | w_pop[i]);
        end
    end

    // Read/write pointer update; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COL; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COL; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
            end
        end
    end

    // Storage array write port; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < COL; i++) begin
            if (!reset && w_push[i]) r_mem[i][r_wptr[i][AW-1:0]] <= in[i*BW +: BW];
        end
    end

    // Registered mode and serial-column selector; a mode change restarts at column 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 1'b0;
            r_sel  <= '0;
        end else if (mode != r_mode) begin
            r_mode <= mode;
            r_sel  <= '0;
        end else if (w_pop_ser) begin
            r_sel  <= (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;
        end
    end

    // Output data registers; they hold their value when nothing is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_out_col <= '0;
            r_out_idx <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_rd_ok;
            if (w_pop_row) begin
                for (int i = 0; i < COL; i++) r_out[i*BW +: BW] <= w_head[i];
            end
            if (w_pop_ser) begin
                r_out_col <= w_head[r_sel];
                r_out_idx <= r_sel;
            end
        end
    end

    assign out     = r_out;
    assign out_col = r_out_col;
    assign out_idx = r_out_idx;
    assign out_vld = r_out_vld;
    assign o_valid = w_valid;
    assign o_full  = |w_full;
    assign o_ready = ~(|w_full);
    assign o_afull = |w_afull;

`ifdef OFIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (|(wr & ~w_push)) r_ovf <= 1'b1;
            if (rd & ~w_valid)   r_unf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
    assign o_unf = r_unf;
`else
    assign o_ovf = 1'b0;
    assign o_unf = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo_multi_mode.sv
// Scoreboard bench for ofifo_multi_mode (COL=4, BW=4, DEPTH=8, AF_LVL=6).
// A queue-based reference model predicts status flags and read data; expected
// read results are queued with their due cycle and checked by a monitor.
module tb_ofifo_multi_mode;

    localparam int COL   = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
`ifdef OFIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in    = '0;
    logic [3:0]  wr    = '0;
    logic        rd    = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] out;
    logic [3:0]  out_col;
    logic [1:0]  out_idx;
    logic        out_vld, o_full, o_ready, o_valid, o_afull, o_ovf, o_unf;

    ofifo_multi_mode #(
        .COL    (COL),
        .BW     (BW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .out     (out),
        .out_col (out_col),
        .out_idx (out_idx),
        .out_vld (out_vld),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_afull (o_afull),
        .o_ovf   (o_ovf),
        .o_unf   (o_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          ser;
        logic [15:0] data;
        logic [3:0]  col;
        logic [1:0]  idx;
    } exp_t;

    exp_t        exp_q [$];
    logic [3:0]  mq [COL][$];
    bit          m_mode;
    int          m_sel;
    bit          m_ovf, m_unf;
    int          cyc     = 0;
    int          clr_cyc = -1;
    bit          mon_en  = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_valid();
        bit v;
        if (m_mode) begin
            v = (mq[m_sel].size() > 0);
        end else begin
            v = 1'b1;
            for (int c = 0; c < COL; c++) if (mq[c].size() == 0) v = 1'b0;
        end
        return v;
    endfunction

    task automatic check_status();
        bit full, afull;
        full  = 1'b0;
        afull = 1'b0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == DEPTH) full = 1'b1;
            if (mq[c].size() >= AF)    afull = 1'b1;
        end
        chk("o_valid", {31'b0, o_valid}, {31'b0, model_valid()});
        chk("o_full",  {31'b0, o_full},  {31'b0, full});
        chk("o_ready", {31'b0, o_ready}, {31'b0, !full});
        chk("o_afull", {31'b0, o_afull}, {31'b0, afull});
        chk("o_ovf",   {31'b0, o_ovf},   {31'b0, ERR_EN & m_ovf});
        chk("o_unf",   {31'b0, o_unf},   {31'b0, ERR_EN & m_unf});
    endtask

    // One clock of stimulus: update the model from the pre-edge state, then drive.
    task automatic step(input logic [3:0] w, input logic [15:0] d, input bit r,
                        input bit md, input bit rst);
        exp_t e;
        if (rst) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_mode  = 1'b0;
            m_sel   = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            clr_cyc = cyc + 1;
        end else begin
            if (r && model_valid()) begin
                e.cyc  = cyc + 1;
                e.ser  = m_mode;
                e.data = '0;
                e.col  = '0;
                e.idx  = 2'(m_sel);
                if (!m_mode) begin
                    for (int c = 0; c < COL; c++) e.data[c*BW +: BW] = mq[c].pop_front();
                end else begin
                    e.col = mq[m_sel].pop_front();
                    m_sel = (m_sel + 1) % COL;
                end
                exp_q.push_back(e);
            end else if (r) begin
                m_unf = 1'b1;
            end
            for (int c = 0; c < COL; c++) begin
                if (w[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(d[c*BW +: BW]);
                    else m_ovf = 1'b1;
                end
            end
            if (md != m_mode) begin
                m_mode = md;
                m_sel  = 0;
            end
        end
        wr    = w;
        in    = d;
        rd    = r;
        mode  = md;
        reset = rst;
        @(posedge clk);
        #1;
        wr    = '0;
        rd    = 1'b0;
        reset = 1'b0;
        check_status();
    endtask

    // Monitor: compares every presented output against the scoreboard and
    // checks that output data holds when out_vld is low.
    initial begin
        exp_t        e;
        logic [15:0] last_out;
        logic [3:0]  last_col;
        logic [1:0]  last_idx;
        last_out = '0;
        last_col = '0;
        last_idx = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cyc == clr_cyc) begin
                    last_out = '0;
                    last_col = '0;
                    last_idx = '0;
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("out_vld", {31'b0, out_vld}, 32'd1);
                    if (e.ser) begin
                        last_col = e.col;
                        last_idx = e.idx;
                    end else begin
                        last_out = e.data;
                    end
                end else begin
                    chk("out_vld", {31'b0, out_vld}, 32'd0);
                end
                chk("out",     {16'b0, out},     {16'b0, last_out});
                chk("out_col", {28'b0, out_col}, {28'b0, last_col});
                chk("out_idx", {30'b0, out_idx}, {30'b0, last_idx});
            end
        end
    end

    initial begin
        logic [15:0] d;
        bit          md;
        @(posedge clk);
        #1;
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;

        // Row read of a single full row.
        step(4'hF, 16'h4321, 1'b0, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Unequal fill, then a read that must underflow.
        for (int k = 0; k < 3; k++) step(4'h1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Fill column 2 to full, drop a ninth write, then read back in order.
        for (int k = 0; k < 8; k++) step(4'h4, 16'(k) << 8, 1'b0, 1'b0, 1'b0);
        step(4'h4, 16'h0900, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(4'hB, 16'($urandom), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(4'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Serial read across all columns, one more read underflows and sel wraps.
        step(4'hF, 16'($urandom), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(4'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        step(4'hF, 16'($urandom), 1'b0, 1'b1, 1'b0);
        step(4'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Simultaneous read and write on a full column 0.
        for (int k = 0; k < 8; k++) step(4'hF, 16'($urandom), 1'b0, 1'b0, 1'b0);
        step(4'h1, 16'h000A, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(4'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Reset with stored entries and a concurrent rd/wr.
        for (int k = 0; k < 5; k++) step(4'hF, 16'($urandom), 1'b0, 1'b0, 1'b0);
        step(4'hF, 16'($urandom), 1'b1, 1'b0, 1'b1);
        step(4'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional mode changes and resets.
        md = 1'b0;
        for (int k = 0; k < 600; k++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) md = ~md;
            step(4'($urandom), d, 1'($urandom), md, ($urandom_range(0, 199) == 0));
        end

        step(4'h0, 16'h0, 1'b0, md, 1'b0);
        step(4'h0, 16'h0, 1'b0, md, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
